// File: rtl/fma_pkg.sv
// rtl/fma_pkg.sv - shared types and constants for the FMA issue/retire wrapper
package fma_pkg;

    localparam int REC_W     = 33;
    localparam int IEEE_W    = 32;
    localparam int FLAG_W    = 5;
    localparam int TAG_W_MAX = 16;

    // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector.
    typedef enum int unsigned {
        FLAG_NX = 0,
        FLAG_UF = 1,
        FLAG_OF = 2,
        FLAG_DZ = 3,
        FLAG_NV = 4
    } flag_idx_e;

    // Recoded exponent at/above which the value is a normal number, and the
    // offset that turns a recoded normal exponent into the biased IEEE one.
    localparam logic [8:0] EXP_NORM_MIN = 9'd130;
    localparam logic [8:0] EXP_BIAS_ADJ = 9'd129;

    // Tag field is sized for the widest tag any instance may use; each
    // instance fills only its low TAG_W bits.
    typedef struct packed {
        logic [REC_W-1:0]     rec;
        logic [FLAG_W-1:0]    flags;
        logic [TAG_W_MAX-1:0] tag;
    } fifo_entry_t;

endpackage

// File: rtl/recfn_to_ieee_f32.sv
// rtl/recfn_to_ieee_f32.sv - combinational recoded FP32 (33b) to IEEE binary32 decoder
//
// Ports:
//   rec_i  : 33-bit recoded value {sign, exp9, frac23}
//   ieee_o : IEEE-754 binary32 encoding of the same value
module recfn_to_ieee_f32
    import fma_pkg::*;
(
    input  logic [REC_W-1:0]  rec_i,
    output logic [IEEE_W-1:0] ieee_o
);

    logic        sign;
    logic [8:0]  exp9;
    logic [22:0] frac;
    logic [23:0] mant;
    logic [8:0]  shamt;

    assign sign  = rec_i[32];
    assign exp9  = rec_i[31:23];
    assign frac  = rec_i[22:0];
    assign mant  = {1'b1, frac};
    // Only meaningful on the subnormal path (exp9 < 130); shifts past 23
    // naturally flush the fraction to zero.
    assign shamt = EXP_NORM_MIN - exp9;

    always_comb begin
        ieee_o = {sign, 31'd0};
        if (exp9[8:6] == 3'b000) begin
            ieee_o = {sign, 31'd0};
        end else if (exp9[8:6] == 3'b110) begin
            ieee_o = {sign, 8'hFF, 23'd0};
        end else if (exp9[8:6] == 3'b111) begin
            ieee_o = {sign, 8'hFF, frac};
        end else if (exp9 >= EXP_NORM_MIN) begin
            ieee_o = {sign, 8'(exp9 - EXP_BIAS_ADJ), frac};
        end else begin
            ieee_o = {sign, 8'h00, 23'(mant >> shamt)};
        end
    end

endmodule

// File: rtl/fma_issue_retire.sv
// rtl/fma_issue_retire.sv - credit-based issue and FIFO retire around a fixed-latency FMA pipe
//
// Ports:
//   clock, reset               : clock, synchronous active-high reset
//   req_*                      : op request (ready/valid), operands, rounding mode, tag
//   pipe_validin, pipe_*       : issue side of the pipe (no backpressure)
//   pipe_validout, pipe_out,
//   pipe_flags                 : result side of the pipe, LAT cycles after issue
//   resp_*                     : retired result (ready/valid), IEEE data, flags, tag
//   fflags_acc, fflags_clr     : sticky OR of retired flags and its clear
module fma_issue_retire
    import fma_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [REC_W-1:0]  req_a,
    input  logic [REC_W-1:0]  req_b,
    input  logic [REC_W-1:0]  req_c,
    input  logic [2:0]        req_rm,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              pipe_validin,
    output logic [1:0]        pipe_op,
    output logic [REC_W-1:0]  pipe_a,
    output logic [REC_W-1:0]  pipe_b,
    output logic [REC_W-1:0]  pipe_c,
    output logic [2:0]        pipe_rm,
    input  logic              pipe_validout,
    input  logic [REC_W-1:0]  pipe_out,
    input  logic [FLAG_W-1:0] pipe_flags,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IEEE_W-1:0] resp_data,
    output logic [FLAG_W-1:0] resp_flags,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [FLAG_W-1:0] fflags_acc,
    input  logic              fflags_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              req_fire;
    logic              resp_fire;

    // Credits: in-flight ops plus FIFO occupancy.
    logic [CNT_W-1:0]  used_q, used_d;

    // Tag delay line, aligned with the pipe latency.
    logic [LAT-1:0]    dl_valid_q;
    logic [TAG_W-1:0]  dl_tag_q [LAT];

    // Result FIFO; pointers carry one extra wrap bit to tell full from empty.
    fifo_entry_t       fifo_mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              fifo_empty;
    logic              fifo_full;
    fifo_entry_t       wr_entry;
    fifo_entry_t       head;
    logic              unused_tag_bits;

    logic [FLAG_W-1:0] acc_q, acc_d;

    // ---------------- issue and credits ----------------
    // Ready looks only at the registered credit count so the consumer's
    // resp_ready never reaches req_ready combinationally.
    assign req_ready    = (used_q < CNT_W'(DEPTH));
    assign req_fire     = req_valid & req_ready;
    assign pipe_validin = req_fire;
    assign pipe_op      = req_op;
    assign pipe_a       = req_a;
    assign pipe_b       = req_b;
    assign pipe_c       = req_c;
    assign pipe_rm      = req_rm;

    always_comb begin
        used_d = used_q;
        case ({req_fire, resp_fire})
            2'b10:   used_d = used_q + CNT_W'(1);
            2'b01:   used_d = used_q - CNT_W'(1);
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            used_q <= '0;
        end else begin
            used_q <= used_d;
        end
    end

    // ---------------- tag delay line ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            dl_valid_q <= '0;
        end else begin
            dl_valid_q[0] <= pipe_validin;
            for (int i = 1; i < LAT; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        dl_tag_q[0] <= req_tag;
        for (int i = 1; i < LAT; i++) begin
            dl_tag_q[i] <= dl_tag_q[i-1];
        end
    end

    // ---------------- result FIFO ----------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    always_comb begin
        wr_entry                = '0;
        wr_entry.rec            = pipe_out;
        wr_entry.flags          = pipe_flags;
        wr_entry.tag[TAG_W-1:0] = dl_tag_q[LAT-1];
    end

    always_ff @(posedge clock) begin
        if (pipe_validout) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (pipe_validout) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (resp_fire) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    assign head            = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign resp_valid      = ~fifo_empty;
    assign resp_fire       = resp_valid & resp_ready;
    assign resp_flags      = head.flags;
    assign resp_tag        = head.tag[TAG_W-1:0];
    assign unused_tag_bits = ^head.tag;

    recfn_to_ieee_f32 u_dec (
        .rec_i  (head.rec),
        .ieee_o (resp_data)
    );

    // ---------------- sticky flags ----------------
    // A clear in the same cycle as a retire keeps only the retiring flags.
    always_comb begin
        acc_d = acc_q;
        if (fflags_clr) begin
            acc_d = resp_fire ? resp_flags : '0;
        end else if (resp_fire) begin
            acc_d = acc_q | resp_flags;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign fflags_acc = acc_q;

    // ---------------- invariants ----------------
    a_tag_align: assert property (@(posedge clock) disable iff (reset)
        dl_valid_q[LAT-1] == pipe_validout);

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(pipe_validout && fifo_full));

endmodule

// File: tb/tb_fma_issue_retire.sv
// tb/tb_fma_issue_retire.sv - randomized self-checking bench for fma_issue_retire
module tb_fma_issue_retire;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid, req_ready;
    logic [1:0]       req_op;
    logic [32:0]      req_a, req_b, req_c;
    logic [2:0]       req_rm;
    logic [TAG_W-1:0] req_tag;
    logic             pipe_validin;
    logic [1:0]       pipe_op;
    logic [32:0]      pipe_a, pipe_b, pipe_c;
    logic [2:0]       pipe_rm;
    logic             pipe_validout;
    logic [32:0]      pipe_out;
    logic [4:0]       pipe_flags;
    logic             resp_valid, resp_ready;
    logic [31:0]      resp_data;
    logic [4:0]       resp_flags;
    logic [TAG_W-1:0] resp_tag;
    logic [4:0]       fflags_acc;
    logic             fflags_clr;

    always #5 clock = ~clock;

    fma_issue_retire #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_rm(req_rm), .req_tag(req_tag),
        .pipe_validin(pipe_validin), .pipe_op(pipe_op), .pipe_a(pipe_a),
        .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_rm(pipe_rm),
        .pipe_validout(pipe_validout), .pipe_out(pipe_out), .pipe_flags(pipe_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_flags(resp_flags), .resp_tag(resp_tag),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
    );

    // Pipe stand-in: result = operand a, flags = operand b[4:0], LAT cycles later.
    logic [LAT-1:0] pv;
    logic [32:0]    pd [LAT];
    logic [4:0]     pf [LAT];

    always @(posedge clock) begin
        if (reset) begin
            pv <= '0;
        end else begin
            pv[0] <= pipe_validin;
            pd[0] <= pipe_a;
            pf[0] <= pipe_b[4:0];
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
                pf[i] <= pf[i-1];
            end
        end
    end

    assign pipe_validout = pv[LAT-1];
    assign pipe_out      = pd[LAT-1];
    assign pipe_flags    = pf[LAT-1];

    typedef struct {
        logic [31:0]      data;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
        int               rdy;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    int          n_ret    = 0;
    int          last_fire_cyc = 0;
    int          last_ret_cyc  = 0;
    logic [4:0]  acc_m = '0;
    logic [31:0] exp_next;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Value-level decode from the recoded format's class ranges.
    function automatic logic [31:0] ieee_ref(input logic [32:0] r);
        int unsigned e9, sh, m;
        logic        s;
        logic [22:0] f;
        logic [7:0]  ex;
        s  = r[32];
        e9 = {23'd0, r[31:23]};
        f  = r[22:0];
        if (e9 < 64)   return {s, 31'd0};
        if (e9 >= 448) return {s, 8'hFF, f};
        if (e9 >= 384) return {s, 8'hFF, 23'd0};
        if (e9 >= 130) begin
            ex = 8'(e9 - 129);
            return {s, ex, f};
        end
        sh = 130 - e9;
        m  = (sh > 24) ? 0 : (32'h0080_0000 + 32'(f)) / (32'd1 << sh);
        return {s, 8'd0, m[22:0]};
    endfunction

    task automatic set_req(input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_op    = 2'($urandom);
        req_a     = {1'($urandom), 32'($urandom)};
        req_b     = {1'($urandom), 32'($urandom)};
        req_c     = {1'($urandom), 32'($urandom)};
        req_rm    = 3'($urandom);
        req_tag   = tag;
        exp_next  = ieee_ref(req_a);
    endtask

    task automatic run_cycle();
        exp_t       e;
        logic       fr, fp;
        logic [4:0] fl;
        @(negedge clock);
        cyc++;
        check("req_ready", 128'(req_ready), 128'(sbq.size() < DEPTH));
        check("resp_valid", 128'(resp_valid), 128'(sbq.size() > 0 && sbq[0].rdy <= cyc));
        check("fflags_acc", 128'(fflags_acc), 128'(acc_m));
        check("issue", 128'({pipe_validin, pipe_op, pipe_a, pipe_b, pipe_c, pipe_rm}),
              128'({req_valid && (sbq.size() < DEPTH), req_op, req_a, req_b, req_c, req_rm}));
        fr = req_valid && req_ready;
        fp = resp_valid && resp_ready;
        fl = '0;
        if (fp) begin
            n_ret++;
            last_ret_cyc = cyc;
            if (sbq.size() == 0) begin
                check("resp_spurious", 128'(1), 128'(0));
            end else begin
                e  = sbq.pop_front();
                fl = e.flags;
                check("resp_data",  128'(resp_data),  128'(e.data));
                check("resp_flags", 128'(resp_flags), 128'(e.flags));
                check("resp_tag",   128'(resp_tag),   128'(e.tag));
            end
        end
        if (fr) begin
            n_acc++;
            last_fire_cyc = cyc;
            sbq.push_back('{exp_next, req_b[4:0], req_tag, cyc + LAT + 1});
        end
        if (fflags_clr) acc_m = fl;
        else            acc_m = acc_m | fl;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        fflags_clr = 1'b0;
        for (int i = 0; i < 40 && sbq.size() > 0; i++) run_cycle();
        check("drain", 128'(sbq.size()), 128'(0));
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        req_valid  = 1'b0;
        fflags_clr = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        sbq.delete();
        acc_m = '0;
    endtask

    logic [32:0] dir_a [7];
    logic [31:0] dir_e [7];
    int          base, low_cnt, max_used, ret_base;

    initial begin
        req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_c = 0; req_rm = 0; req_tag = 0;
        resp_ready = 0; fflags_clr = 0; exp_next = 0;
        do_reset(3);

        // Reset state.
        check("rst_req_ready",  128'(req_ready),  128'(1));
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_fflags",     128'(fflags_acc), 128'(0));
        run_cycle();

        // Single op: 1.0, tag 7, response LAT+1 cycles after the fire.
        resp_ready = 1'b1;
        set_req(5'd7);
        req_a = 33'h0_8000_0000; req_b = 33'h0; exp_next = 32'h3F80_0000;
        run_cycle();
        base = last_fire_cyc;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && sbq.size() > 0; i++) run_cycle();
        check("single_latency", 128'(last_ret_cyc - base), 128'(LAT + 1));

        // Decoder directed values.
        dir_a = '{33'h0_0000_0000, 33'h1_C000_0000, 33'h0_E040_0000, {1'b0, 9'd129, 23'd0},
                  {1'b0, 9'd107, 23'd0}, 33'h0_80C0_0000, {1'b1, 9'd128, 23'h20_0000}};
        dir_e = '{32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0040_0000,
                  32'h0000_0001, 32'h4040_0000, 32'h8028_0000};
        for (int i = 0; i < 7; i++) begin
            set_req(5'(i));
            req_a = dir_a[i];
            exp_next = dir_e[i];
            run_cycle();
        end
        drain();

        // Backpressure: exactly DEPTH accepts, then in-order release.
        resp_ready = 1'b0;
        base = n_acc;
        for (int i = 0; i < 8; i++) begin
            set_req(5'(n_acc - base));
            run_cycle();
        end
        check("bp_accepts", 128'(n_acc - base), 128'(4));
        check("bp_ready_low", 128'(req_ready), 128'(0));
        drain();

        // Streaming: 100 back-to-back ops with a ready consumer.
        resp_ready = 1'b1;
        base = n_acc; ret_base = n_ret; low_cnt = 0; max_used = 0;
        for (int i = 0; i < 100; i++) begin
            set_req(5'(i));
            if (!req_ready) low_cnt++;
            run_cycle();
            if (int'(dut.used_q) > max_used) max_used = int'(dut.used_q);
        end
        drain();
        check("stream_accepts", 128'(n_acc - base), 128'(100));
        check("stream_ready_low", 128'(low_cnt), 128'(0));
        check("stream_responses", 128'(n_ret - ret_base), 128'(100));
        check("stream_max_used", 128'(max_used), 128'(3));

        // Sticky flags.
        fflags_clr = 1'b1;
        run_cycle();
        fflags_clr = 1'b0;
        set_req(5'd1); req_b[4:0] = 5'b00001; run_cycle();
        set_req(5'd2); req_b[4:0] = 5'b10000; run_cycle();
        drain();
        check("acc_or", 128'(fflags_acc), 128'(5'b10001));
        resp_ready = 1'b0;
        set_req(5'd3); req_b[4:0] = 5'b00100; run_cycle();
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !resp_valid; i++) run_cycle();
        check("flags_wait", 128'(resp_valid), 128'(1));
        resp_ready = 1'b1;
        fflags_clr = 1'b1;
        run_cycle();
        fflags_clr = 1'b0;
        check("acc_clr_fire", 128'(fflags_acc), 128'(5'b00100));

        // Random mix.
        for (int i = 0; i < 300; i++) begin
            set_req(5'($urandom));
            req_valid  = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 2) != 0);
            fflags_clr = ($urandom_range(0, 15) == 0);
            run_cycle();
        end
        drain();

        // Reset with ops in flight.
        set_req(5'd9); req_b[4:0] = 5'b01000; run_cycle();
        drain();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(5'(20 + i));
            run_cycle();
        end
        do_reset(1);
        check("mid_rst_resp_valid", 128'(resp_valid), 128'(0));
        check("mid_rst_fflags",     128'(fflags_acc), 128'(0));
        check("mid_rst_req_ready",  128'(req_ready),  128'(1));
        resp_ready = 1'b1;
        ret_base = n_ret;
        for (int i = 0; i < 10; i++) run_cycle();
        check("mid_rst_no_stale", 128'(n_ret - ret_base), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
